// File: rtl/mem_access_unit.sv
// Load/store unit between EX and DM/WB: sizes and aligns accesses, drives a
// single-outstanding request bus and returns load data or exception flags.
module mem_access_unit #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            e_valid,
    input  logic            e_mem_read,
    input  logic            e_mem_write,
    input  logic            e_reg_write,
    input  logic [2:0]      e_funct3,
    input  logic [XLEN-1:0] e_addr,
    input  logic [XLEN-1:0] e_wdata,
    input  logic [XLEN-1:0] e_alu_result,
    input  logic [RA_W-1:0] e_rd,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    input  logic            bus_ready,
    input  logic            bus_err,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            stall,
    output logic            m_valid,
    output logic            m_reg_write,
    output logic [XLEN-1:0] m_dataout,
    output logic [RA_W-1:0] m_rd,
    output logic            m_exc_misaligned,
    output logic            m_exc_bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state, state_next;
    logic [1:0]      addr_lo;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    // funct3[1:0]: 00 byte, 01 half, anything else (incl. undefined codes) word
    logic            e_is_byte, e_is_half, mem_op, misaligned;
    logic [XLEN-1:0] shifted, load_data;

    assign e_is_byte  = (e_funct3[1:0] == 2'b00);
    assign e_is_half  = (e_funct3[1:0] == 2'b01);
    assign mem_op     = e_valid & (e_mem_read | e_mem_write);
    assign misaligned = (e_is_half & e_addr[0]) |
                        (!e_is_byte && !e_is_half && (e_addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            addr_lo  <= '0;
            funct3_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && mem_op && !misaligned) begin
                addr_lo  <= e_addr[1:0];
                funct3_q <= e_funct3;
            end
            if (state == REQ && bus_ready) begin
                rdata_q <= bus_rdata;
                err_q   <= bus_err;
            end
        end
    end

    assign shifted = rdata_q >> {addr_lo, 3'b000};

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   load_data = {{(XLEN-8){~funct3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{(XLEN-16){~funct3_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_data = rdata_q;
        endcase
    end

    // Upstream holds its outputs while stalled, so the bus fields can come
    // straight from the e_* inputs and stay stable across the REQ cycles.
    assign bus_addr = {e_addr[XLEN-1:2], 2'b00};

    always_comb begin
        if (e_is_byte) begin
            bus_be    = 4'b0001 << e_addr[1:0];
            bus_wdata = {(XLEN/8){e_wdata[7:0]}};
        end else if (e_is_half) begin
            bus_be    = 4'b0011 << e_addr[1:0];
            bus_wdata = {(XLEN/16){e_wdata[15:0]}};
        end else begin
            bus_be    = 4'b1111;
            bus_wdata = e_wdata;
        end
    end

    always_comb begin
        state_next       = state;
        stall            = 1'b0;
        bus_req          = 1'b0;
        bus_we           = 1'b0;
        m_valid          = 1'b0;
        m_reg_write      = 1'b0;
        m_dataout        = e_alu_result;
        m_rd             = e_rd;
        m_exc_misaligned = 1'b0;
        m_exc_bus_err    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        m_valid          = 1'b1;
                        m_exc_misaligned = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        state_next = REQ;
                    end
                end else begin
                    m_valid     = e_valid;
                    m_reg_write = e_reg_write & e_valid;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                bus_we  = e_mem_write;
                stall   = 1'b1;
                if (bus_ready) state_next = RESP;
            end
            RESP: begin
                m_valid    = 1'b1;
                state_next = IDLE;
                if (err_q) begin
                    m_exc_bus_err = 1'b1;
                    m_dataout     = '0;
                end else if (!e_mem_write) begin
                    m_dataout   = load_data;
                    m_reg_write = e_reg_write;
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            stall            = 1'b0;
            bus_req          = 1'b0;
            bus_we           = 1'b0;
            m_exc_misaligned = 1'b0;
            m_exc_bus_err    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: a reference model predicts
// every pipeline result and bus request; monitors compare what the DUT presents.
module tb_mem_access_unit;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            e_valid, e_mem_read, e_mem_write, e_reg_write;
    logic [2:0]      e_funct3;
    logic [XLEN-1:0] e_addr, e_wdata, e_alu_result;
    logic [RA_W-1:0] e_rd;
    logic            bus_req, bus_we;
    logic [XLEN-1:0] bus_addr, bus_wdata;
    logic [3:0]      bus_be;
    logic            bus_ready = 1'b0, bus_err = 1'b0;
    logic [XLEN-1:0] bus_rdata = '0;
    logic            stall, m_valid, m_reg_write;
    logic [XLEN-1:0] m_dataout;
    logic [RA_W-1:0] m_rd;
    logic            m_exc_misaligned, m_exc_bus_err;

    mem_access_unit #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .reset(reset),
        .e_valid(e_valid), .e_mem_read(e_mem_read), .e_mem_write(e_mem_write),
        .e_reg_write(e_reg_write), .e_funct3(e_funct3), .e_addr(e_addr),
        .e_wdata(e_wdata), .e_alu_result(e_alu_result), .e_rd(e_rd),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ready(bus_ready),
        .bus_err(bus_err), .bus_rdata(bus_rdata), .stall(stall),
        .m_valid(m_valid), .m_reg_write(m_reg_write), .m_dataout(m_dataout),
        .m_rd(m_rd), .m_exc_misaligned(m_exc_misaligned), .m_exc_bus_err(m_exc_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic        berr;
    } out_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    out_t out_q[$];
    bus_t bus_q[$];
    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    logic [31:0] rsp_rdata = '0;
    logic        rsp_err = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int unsigned acc_size(input logic [2:0] f);
        case (f)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input int unsigned a,
                                             input logic [31:0] rdata);
        int unsigned v;
        v = rdata >> (8 * a);
        if (acc_size(f) == 1) begin
            v = v % 256;
            if (f == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (acc_size(f) == 2) begin
            v = v % 65536;
            if (f == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f, input int unsigned a);
        int unsigned m;
        if (acc_size(f) == 4) return 4'hF;
        m = (acc_size(f) == 1) ? 1 : 3;
        return 4'((m << a) % 16);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f, input logic [31:0] w);
        case (acc_size(f))
            1:       return (w % 256) * 32'h0101_0101;
            2:       return (w % 65536) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    // Issue one instruction, predict its result, and hold it until stall drops.
    task automatic issue(input logic v, input logic rd_en, input logic wr_en, input logic rw,
                         input logic [2:0] f, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] alu, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic err, input int d);
        logic mem, mis;
        int unsigned a, n;
        out_t eo;
        bus_t eb;
        a   = addr % 4;
        mem = v && (rd_en || wr_en);
        mis = mem && ((addr % acc_size(f)) != 0);
        if (v) begin
            eo = '{data: alu, rd: rd, rw: 1'b0, mis: 1'b0, berr: 1'b0};
            if (!mem)         eo.rw = rw;
            else if (mis)     eo.mis = 1'b1;
            else if (err)     begin eo.berr = 1'b1; eo.data = '0; end
            else if (!wr_en)  begin eo.data = ref_load(f, a, rdata); eo.rw = rw; end
            out_q.push_back(eo);
        end
        if (mem && !mis) begin
            eb = '{addr: addr - a, we: wr_en, be: ref_be(f, a), wdata: ref_wdata(f, wdata)};
            bus_q.push_back(eb);
            ready_cnt = d;
            rsp_rdata = rdata;
            rsp_err   = err;
        end
        @(posedge clk);
        #1;
        e_valid = v; e_mem_read = rd_en; e_mem_write = wr_en; e_reg_write = rw;
        e_funct3 = f; e_addr = addr; e_wdata = wdata; e_alu_result = alu; e_rd = rd;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 60) begin
                chk("stall_timeout", 128'(n), 128'(0));
                break;
            end
        end
        chk("stall_cycles", 128'(n), 128'((mem && !mis) ? 2 + d : 0));
    endtask

    always @(negedge clk) begin
        out_t got, exp;
        if (!reset && m_valid) begin
            got = '{data: m_dataout, rd: m_rd, rw: m_reg_write,
                    mis: m_exc_misaligned, berr: m_exc_bus_err};
            if (out_q.size() == 0) begin
                chk("spurious_m_valid", 128'(got), 128'(0));
            end else begin
                exp = out_q.pop_front();
                chk("m_result", 128'(got), 128'(exp));
            end
        end
    end

    // Memory model: answers after ready_cnt wait cycles, garbage data otherwise.
    always @(negedge clk) begin
        bus_t got, exp;
        bus_ready = 1'b0;
        bus_rdata = $urandom;
        bus_err   = 1'($urandom_range(0, 1));
        if (!reset && bus_req) begin
            if (bus_q.size() == 0) begin
                chk("spurious_bus_req", 128'(1), 128'(0));
            end else begin
                exp = bus_q[0];
                got = '{addr: bus_addr, we: bus_we, be: bus_be, wdata: bus_wdata};
                if (!exp.we) begin
                    got.be = '0; got.wdata = '0;
                    exp.be = '0; exp.wdata = '0;
                end
                chk("bus_fields", 128'(got), 128'(exp));
                if (ready_cnt == 0) begin
                    bus_ready = 1'b1;
                    bus_rdata = rsp_rdata;
                    bus_err   = rsp_err;
                    void'(bus_q.pop_front());
                end else begin
                    ready_cnt--;
                end
            end
        end
    end

    initial begin
        int unsigned kind, n;
        logic [31:0] addr;
        reset = 1'b1;
        e_valid = 1'b1; e_mem_read = 1'b1; e_mem_write = 1'b0; e_reg_write = 1'b1;
        e_funct3 = 3'b010; e_addr = 32'h101; e_wdata = '0; e_alu_result = '0; e_rd = '0;
        #2;
        chk("rst_misaligned_flag", 128'(m_exc_misaligned), 128'(0));
        chk("rst_bus_err_flag", 128'(m_exc_bus_err), 128'(0));
        e_addr = 32'h100;
        #1;
        chk("rst_stall", 128'(stall), 128'(0));
        chk("rst_bus_req", 128'(bus_req), 128'(0));
        repeat (2) @(posedge clk);
        chk("rst_bus_req_clk", 128'(bus_req), 128'(0));
        @(negedge clk);
        e_valid = 1'b0;
        reset = 1'b0;

        // Directed cases
        issue(1, 0, 0, 1, 3'b000, 32'h0, 32'h0, 32'h1234, 5'd5, 32'h0, 0, 0);
        issue(1, 1, 0, 1, 3'b000, 32'h103, 32'h0, 32'h55, 5'd7, 32'h80FF_0000, 0, 1);
        issue(1, 0, 1, 1, 3'b001, 32'h102, 32'hABCD, 32'h66, 5'd9, 32'h0, 0, 0);
        issue(1, 1, 0, 1, 3'b010, 32'h101, 32'h0, 32'h77, 5'd3, 32'h0, 0, 0);
        issue(1, 1, 0, 1, 3'b101, 32'h202, 32'h0, 32'h88, 5'd4, 32'hDEAD_BEEF, 1, 2);
        issue(1, 1, 1, 1, 3'b000, 32'h301, 32'h5A, 32'h99, 5'd6, 32'h1234_5678, 0, 0);
        issue(1, 1, 0, 1, 3'b011, 32'h404, 32'h0, 32'h11, 5'd8, 32'hCAFE_F00D, 0, 0);
        issue(0, 1, 0, 1, 3'b010, 32'h500, 32'h0, 32'h22, 5'd2, 32'h0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            addr = $urandom;
            issue(1'($urandom_range(0, 7) != 0), 1'(kind == 1 || kind == 3),
                  1'(kind >= 2), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  addr, $urandom, $urandom, 5'($urandom), $urandom,
                  1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)));
        end

        // Reset while a request is waiting on the bus
        bus_q.push_back('{addr: 32'h600, we: 1'b0, be: 4'h0, wdata: '0});
        ready_cnt = 20;
        @(posedge clk);
        #1;
        e_valid = 1'b1; e_mem_read = 1'b1; e_mem_write = 1'b0; e_reg_write = 1'b1;
        e_funct3 = 3'b010; e_addr = 32'h600; e_rd = 5'd10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_req && n < 10);
        chk("mid_req_reached", 128'(bus_req), 128'(1));
        #2 reset = 1'b1;
        #1;
        chk("mid_req_bus_req", 128'(bus_req), 128'(0));
        chk("mid_req_stall", 128'(stall), 128'(0));
        bus_q.delete();
        ready_cnt = 0;
        @(posedge clk);
        #1 e_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_bus_req", 128'(bus_req), 128'(0));
        issue(1, 0, 0, 1, 3'b000, 32'h0, 32'h0, 32'hBEEF, 5'd12, 32'h0, 0, 0);

        @(posedge clk);
        #1 e_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("out_q_drained", 128'(out_q.size()), 128'(0));
        chk("bus_q_drained", 128'(bus_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data/address width.
REQ-002 Parameter RA_W, default 5, SHALL set the register address width.
REQ-003 clk  in  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 e_valid  in  1  SHALL mark the upstream instruction as valid.
REQ-006 e_mem_read, e_mem_write, e_reg_write  in  1 each  SHALL carry the load, store and register-write controls.
REQ-007 e_funct3  in  3  SHALL carry the access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 e_addr, e_wdata, e_alu_result  in  XLEN each  SHALL carry the byte address, store data and ALU result.
REQ-009 e_rd  in  RA_W  SHALL carry the destination register.
REQ-010 bus_req, bus_we  out  1  SHALL carry the memory request and the write strobe.
REQ-011 bus_addr, bus_wdata  out  XLEN  SHALL carry the word-aligned address (addr[1:0]=00) and the lane-replicated store data.
REQ-012 bus_be  out  4  SHALL carry the byte enables.
REQ-013 bus_ready, bus_err  in  1  and bus_rdata  in  XLEN  SHALL carry the memory response.
REQ-014 stall  out  1  SHALL be high while upstream must hold its outputs.
REQ-015 m_valid, m_reg_write  out  1, m_dataout  out  XLEN, m_rd  out  RA_W  SHALL feed the DM/WB pipeline register.
REQ-016 m_exc_misaligned, m_exc_bus_err  out  1  SHALL flag exceptions.

Function
REQ-017 FSM states SHALL be IDLE, REQ and RESP.
REQ-018 IDLE, no memory op (or e_valid=0): outputs combinational; m_dataout=e_alu_result, m_rd=e_rd, m_reg_write=e_reg_write&e_valid, m_valid=e_valid, stall=0.
REQ-019 IDLE, aligned memory op: stall=1, m_valid=0; latch e_addr[1:0] and e_funct3; next state REQ.
REQ-020 Misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0): no bus request, stall=0, m_valid=1, m_exc_misaligned=1, m_reg_write=0; remain in IDLE.
REQ-021 REQ: bus_req=1, stall=1, m_valid=0; bus_addr, bus_we, bus_be and bus_wdata held stable until bus_ready=1.
REQ-022 REQ with bus_ready=1 at a rising edge: capture bus_rdata and bus_err; next state RESP.
REQ-023 RESP: bus_req=0, stall=0, m_valid=1, m_rd=e_rd; lasts exactly one cycle; next state IDLE.
REQ-024 Minimum memory-op latency SHALL be 3 cycles (IDLE, REQ, RESP), plus one cycle per additional REQ cycle without bus_ready.
REQ-025 Load result SHALL be rdata shifted right by 8*addr[1:0], then sign-extended (B, H) or zero-extended (BU, HU); W is passed unmodified.
REQ-026 Store byte enables: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
REQ-027 Store data: B = byte replicated 4x; H = halfword replicated 2x; W = unmodified.
REQ-028 In RESP, a store SHALL give m_reg_write=0 and m_dataout=e_alu_result.
REQ-029 Undefined funct3 (011, 110, 111) SHALL be treated as W.
REQ-030 bus_err=1 in RESP SHALL set m_exc_bus_err=1, force m_reg_write=0 and set m_dataout=0.
REQ-031 An op with both e_mem_read and e_mem_write set SHALL be treated as a store.

Reset
REQ-032 Reset SHALL force state IDLE and clear the latched address bits, funct3, rdata and error bits to 0.
REQ-033 During reset, bus_req=0, stall=0 and both exception flags=0.
REQ-034 Reset asserted in REQ SHALL drop bus_req in the same cycle without waiting for bus_ready; no response is produced.

Verification
REQ-035 ALU op, e_alu_result=0x1234, rd=5 -> same cycle m_dataout=0x1234, m_rd=5, m_reg_write=1, stall=0.
REQ-036 LB addr=0x103, bus_rdata=0x80FF0000, ready after 2 REQ cycles -> bus_addr=0x100; stall high for 3 cycles; RESP m_dataout=0xFFFFFF80.
REQ-037 SH addr=0x102, e_wdata=0xABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1; RESP m_reg_write=0.
REQ-038 LW addr=0x101 -> no bus_req, m_exc_misaligned=1, m_reg_write=0, stall=0.
REQ-039 LHU with bus_err=1 on ready -> RESP m_exc_bus_err=1, m_dataout=0, m_reg_write=0.
REQ-040 Reset mid-REQ -> bus_req=0 immediately; state IDLE; next ALU op passes through normally.
